tage_provider_select: RTL and testbench
=======================================

# tage_provider_select

Parametrised TAGE final-prediction stage for NB tagged banks plus a bimodal base table. It selects the provider, the longest-history bank with a tag hit, and the alternate, the next-longest hit or bimodal. It applies a "use alternate on newly allocated" policy driven by a saturating counter that is trained from resolved branches. It sits after the per-bank tag-compare/counter-read stage and drives the registered branch prediction to fetch.

## Interface
- NB, 4, number of tagged banks; bank i (1..NB) has longer history than bank i-1.
- CL, 3, prediction counter width; MSB = taken.
- UA, 4, use-alt-on-NA counter width.
- IW, $clog2(NB+1), bank index width; index 0 = bimodal.
- CLK  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- lookup_valid  in  1  lookup inputs valid this cycle.
- tag_eq  in  NB  bit i-1 = tag hit in bank i.
- Bimodal_C_bit  in  CL  bimodal counter.
- C_bits  in  NB*CL  bank i counter at [(i-1)*CL +: CL].
- upd_valid  in  1  resolved-branch update strobe.
- upd_weak_provider  in  1  resolved branch had a weak tagged provider.
- upd_provider_taken  in  1  provider prediction at lookup time.
- upd_alt_taken  in  1  alternate prediction at lookup time.
- upd_outcome  in  1  actual direction.
- pred_valid  out  1  registered prediction valid.
- branch_prediction  out  1  final prediction.
- alt_prediction  out  1  alternate's prediction.
- provider_idx  out  IW  provider bank index.
- alt_idx  out  IW  alternate bank index.
- provider_weak  out  1  provider counter was weak.
- used_alt  out  1  final prediction taken from alternate.
- use_alt_ctr  out  UA  current counter value, for debug and verification.

## Operation
- Provider is the highest i with tag_eq[i-1]=1, else 0 (bimodal). Alternate is the highest hit below the provider, else 0. If the provider is 0, the alternate is 0.
- pred(k) is the MSB of the counter of bank k; bank 0 uses Bimodal_C_bit.
- Weak means the counter equals 2^(CL-1) or 2^(CL-1)-1 (3 or 4 for CL=3). Bimodal is never treated as weak for selection, so provider_weak=0 when provider_idx=0.
- used_alt = provider_idx≠0 AND provider weak AND use_alt_ctr[UA-1]. branch_prediction = used_alt ? pred(alt) : pred(provider).
- Counter training: when upd_valid, upd_weak_provider and upd_provider_taken≠upd_alt_taken all hold, the counter is updated. If upd_alt_taken==upd_outcome it increments, saturating at 2^UA-1. Otherwise it decrements, saturating at 0. Any other case leaves it unchanged.

## Timing
- Reset (reset=0 at posedge): all outputs 0 and use_alt_ctr=2^(UA-1)-1 (7 for UA=4). Reset overrides any concurrent lookup or update, including a reset asserted mid-stream.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. pred_valid at N+1 equals lookup_valid at N.
- When lookup_valid=0, pred_valid drops to 0 and all other prediction outputs hold their previous values.
- Simultaneous lookup and update in the same cycle: selection uses the pre-update counter value. The new value is visible to lookups from the next cycle.
- There is no backpressure; a new lookup is accepted every cycle.

## Structure
- Shared package tage_pkg holds:
  - CL, the IW computation, and the reset constant for the use-alt counter;
  - function is_weak(ctr);
  - function hit_index(tag_eq, below) for the priority search.
- One sub-module, tage_sat_ctr: a parametrised UA-bit saturating up/down counter with synchronous active-low reset and a reset-value parameter. It holds use_alt_ctr.
- The selection logic is combinational inside this block and feeds a single output register stage.

## Test plan
NB=4, CL=3, UA=4.
- **Reset:** hold reset=0 for 2 cycles with lookup_valid=1 → all outputs 0, use_alt_ctr=7.
- **Provider/alternate select:** tag_eq=4'b0101, bank3=6, bank1=1 → next cycle provider_idx=3, alt_idx=1, branch_prediction=1, alt_prediction=0, used_alt=0, pred_valid=1.
- **Bimodal fallback:** tag_eq=0, Bimodal_C_bit=4 → provider_idx=0, alt_idx=0, branch_prediction=1, provider_weak=0.
- **Use-alt switch:** tag_eq=4'b1000, bank4=3, Bimodal=7, ctr=7 → prediction 0, used_alt=0. Then one update (weak=1, prov=0, alt=1, outcome=1) → ctr=8, and the same lookup gives prediction 1, used_alt=1.
- **Saturation:** 12 alt-correct updates → ctr=15 and holds. Then 20 provider-correct updates → ctr=0 and holds. Updates with prov==alt or weak=0 leave ctr unchanged.
- **Same-cycle and reset cases:** lookup and update in the same cycle at ctr=7 → that prediction uses 7 and the next uses 8. reset=0 mid-stream → outputs 0 and ctr=7 on the next edge.

Source files
------------

// File: rtl/tage_pkg.sv
// Shared TAGE definitions: counter widths, index sizing and the
// selection helpers used by the final-prediction stage.
package tage_pkg;

   localparam int unsigned CL     = 3;
   localparam int unsigned UA_DEF = 4;
   localparam int unsigned NB_MAX = 16;
   localparam int unsigned IW_MAX = $clog2(NB_MAX + 1);

   function automatic int unsigned iw(input int unsigned nb);
      return $clog2(nb + 1);
   endfunction

   // Counter value just below "taken", so a fresh design leans to the provider.
   function automatic int unsigned use_alt_rst(input int unsigned ua);
      return (1 << (ua - 1)) - 1;
   endfunction

   function automatic logic is_weak(input logic [CL-1:0] ctr);
      return (ctr == {1'b1, {(CL-1){1'b0}}}) || (ctr == {1'b0, {(CL-1){1'b1}}});
   endfunction

   // Highest 1-based bank index with a hit strictly below 'below', else 0.
   function automatic logic [IW_MAX-1:0] hit_index(input logic [NB_MAX-1:0] hits,
                                                   input int unsigned below);
      logic [IW_MAX-1:0] idx;
      idx = '0;
      for (int unsigned i = 1; i <= NB_MAX; i++) begin
         if (hits[i-1] && (i < below))
            idx = IW_MAX'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tage_sat_ctr.sv
// Saturating up/down counter with synchronous active-low reset to RST_VAL.
module tage_sat_ctr #(
   parameter int unsigned W       = 4,
   parameter int unsigned RST_VAL = 7
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK) begin
      if (!reset)
         count <= W'(RST_VAL);
      else if (inc && (count != '1))
         count <= count + 1'b1;
      else if (dec && (count != '0))
         count <= count - 1'b1;
   end

endmodule

// File: rtl/tage_provider_select.sv
// TAGE final-prediction stage: provider/alternate selection with the
// use-alternate-on-newly-allocated policy, one registered output stage.
module tage_provider_select
   import tage_pkg::*;
#(
   parameter int unsigned NB = 4,
   parameter int unsigned UA = UA_DEF,
   localparam int unsigned IW = iw(NB)
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            lookup_valid,
   input  logic [NB-1:0]   tag_eq,
   input  logic [CL-1:0]   Bimodal_C_bit,
   input  logic [NB*CL-1:0] C_bits,
   input  logic            upd_valid,
   input  logic            upd_weak_provider,
   input  logic            upd_provider_taken,
   input  logic            upd_alt_taken,
   input  logic            upd_outcome,
   output logic            pred_valid,
   output logic            branch_prediction,
   output logic            alt_prediction,
   output logic [IW-1:0]   provider_idx,
   output logic [IW-1:0]   alt_idx,
   output logic            provider_weak,
   output logic            used_alt,
   output logic [UA-1:0]   use_alt_ctr
);

   logic [NB_MAX-1:0] hits;
   logic [CL-1:0]     ctr_tab [NB+1];
   logic [IW-1:0]     prov_sel, alt_sel;
   logic [CL-1:0]     prov_ctr, alt_ctr;
   logic              prov_weak_c, use_alt_c, final_c;
   logic              train, ctr_inc, ctr_dec;

   always_comb begin
      hits = '0;
      hits[NB-1:0] = tag_eq;
      ctr_tab[0] = Bimodal_C_bit;
      for (int unsigned i = 1; i <= NB; i++)
         ctr_tab[i] = C_bits[(i-1)*CL +: CL];

      prov_sel = IW'(hit_index(hits, NB + 1));
      alt_sel  = (prov_sel == '0) ? '0 : IW'(hit_index(hits, 32'(prov_sel)));
      prov_ctr = ctr_tab[prov_sel];
      alt_ctr  = ctr_tab[alt_sel];

      // Bimodal never counts as weak, so it can never hand over to an alternate.
      prov_weak_c = (prov_sel != '0) && is_weak(prov_ctr);
      use_alt_c   = prov_weak_c && use_alt_ctr[UA-1];
      final_c     = use_alt_c ? alt_ctr[CL-1] : prov_ctr[CL-1];
   end

   always_comb begin
      train   = upd_valid && upd_weak_provider && (upd_provider_taken != upd_alt_taken);
      ctr_inc = train && (upd_alt_taken == upd_outcome);
      ctr_dec = train && (upd_alt_taken != upd_outcome);
   end

   tage_sat_ctr #(
      .W       (UA),
      .RST_VAL (use_alt_rst(UA))
   ) u_use_alt_ctr (
      .CLK   (CLK),
      .reset (reset),
      .inc   (ctr_inc),
      .dec   (ctr_dec),
      .count (use_alt_ctr)
   );

   always_ff @(posedge CLK) begin
      if (!reset) begin
         pred_valid        <= 1'b0;
         branch_prediction <= 1'b0;
         alt_prediction    <= 1'b0;
         provider_idx      <= '0;
         alt_idx           <= '0;
         provider_weak     <= 1'b0;
         used_alt          <= 1'b0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            branch_prediction <= final_c;
            alt_prediction    <= alt_ctr[CL-1];
            provider_idx      <= prov_sel;
            alt_idx           <= alt_sel;
            provider_weak     <= prov_weak_c;
            used_alt          <= use_alt_c;
         end
      end
   end

endmodule

// File: tb/tb_tage_provider_select.sv
// Directed-vector bench for tage_provider_select (NB=4, CL=3, UA=4).
module tb_tage_provider_select;

   logic        CLK = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [3:0]  tag_eq;
   logic [2:0]  Bimodal_C_bit;
   logic [11:0] C_bits;
   logic        upd_valid, upd_weak_provider, upd_provider_taken, upd_alt_taken, upd_outcome;
   logic        pred_valid, branch_prediction, alt_prediction, provider_weak, used_alt;
   logic [2:0]  provider_idx, alt_idx;
   logic [3:0]  use_alt_ctr;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 CLK = ~CLK;

   tage_provider_select #(.NB(4), .UA(4)) dut (
      .CLK                (CLK),
      .reset              (reset),
      .lookup_valid       (lookup_valid),
      .tag_eq             (tag_eq),
      .Bimodal_C_bit      (Bimodal_C_bit),
      .C_bits             (C_bits),
      .upd_valid          (upd_valid),
      .upd_weak_provider  (upd_weak_provider),
      .upd_provider_taken (upd_provider_taken),
      .upd_alt_taken      (upd_alt_taken),
      .upd_outcome        (upd_outcome),
      .pred_valid         (pred_valid),
      .branch_prediction  (branch_prediction),
      .alt_prediction     (alt_prediction),
      .provider_idx       (provider_idx),
      .alt_idx            (alt_idx),
      .provider_weak      (provider_weak),
      .used_alt           (used_alt),
      .use_alt_ctr        (use_alt_ctr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_upd(input logic v, input logic w, input logic p, input logic a, input logic o);
      upd_valid = v; upd_weak_provider = w; upd_provider_taken = p;
      upd_alt_taken = a; upd_outcome = o;
   endtask

   task automatic check_pred(input string tag, input logic pv, input logic bp, input logic ap,
                             input logic [2:0] pi, input logic [2:0] ai,
                             input logic pw, input logic ua);
      check({tag, ".pred_valid"}, pv, pv === 1'bx ? 1'b0 : pv);
   endtask

   initial begin
      reset = 1'b0; lookup_valid = 1'b1; tag_eq = 4'b1111;
      Bimodal_C_bit = 3'd7; C_bits = 12'hfff;
      set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset held for two cycles with activity on the inputs
      tick(); tick();
      check("rst.pred_valid", pred_valid, 0);
      check("rst.branch_prediction", branch_prediction, 0);
      check("rst.alt_prediction", alt_prediction, 0);
      check("rst.provider_idx", provider_idx, 0);
      check("rst.alt_idx", alt_idx, 0);
      check("rst.provider_weak", provider_weak, 0);
      check("rst.used_alt", used_alt, 0);
      check("rst.use_alt_ctr", use_alt_ctr, 7);

      // Provider bank3 (ctr 6), alternate bank1 (ctr 1)
      reset = 1'b1;
      set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tag_eq = 4'b0101; Bimodal_C_bit = 3'd0;
      C_bits = {3'd0, 3'd6, 3'd0, 3'd1};
      tick();
      check("sel.provider_idx", provider_idx, 3);
      check("sel.alt_idx", alt_idx, 1);
      check("sel.branch_prediction", branch_prediction, 1);
      check("sel.alt_prediction", alt_prediction, 0);
      check("sel.used_alt", used_alt, 0);
      check("sel.pred_valid", pred_valid, 1);
      check("sel.provider_weak", provider_weak, 0);

      // No hits: bimodal at weak value 4 is still not weak
      tag_eq = 4'b0000; Bimodal_C_bit = 3'd4;
      tick();
      check("bim.provider_idx", provider_idx, 0);
      check("bim.alt_idx", alt_idx, 0);
      check("bim.branch_prediction", branch_prediction, 1);
      check("bim.alt_prediction", alt_prediction, 1);
      check("bim.provider_weak", provider_weak, 0);

      // lookup_valid low: outputs hold, pred_valid drops
      lookup_valid = 1'b0; tag_eq = 4'b0101; Bimodal_C_bit = 3'd0;
      tick();
      check("hold.pred_valid", pred_valid, 0);
      check("hold.provider_idx", provider_idx, 0);
      check("hold.branch_prediction", branch_prediction, 1);

      // Weak bank4 (ctr 3) over bimodal 7 with ctr=7: provider used
      lookup_valid = 1'b1; tag_eq = 4'b1000; Bimodal_C_bit = 3'd7;
      C_bits = {3'd3, 9'd0};
      tick();
      check("ua0.provider_idx", provider_idx, 4);
      check("ua0.alt_idx", alt_idx, 0);
      check("ua0.provider_weak", provider_weak, 1);
      check("ua0.branch_prediction", branch_prediction, 0);
      check("ua0.alt_prediction", alt_prediction, 1);
      check("ua0.used_alt", used_alt, 0);

      // Same-cycle lookup+update: this lookup still sees ctr=7
      set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("same.use_alt_ctr", use_alt_ctr, 8);
      check("same.branch_prediction", branch_prediction, 0);
      check("same.used_alt", used_alt, 0);
      set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("ua1.use_alt_ctr", use_alt_ctr, 8);
      check("ua1.branch_prediction", branch_prediction, 1);
      check("ua1.used_alt", used_alt, 1);

      // Saturate upward: 12 alt-correct updates from 8
      lookup_valid = 1'b0;
      set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) tick();
      check("sat.hi", use_alt_ctr, 15);
      tick();
      check("sat.hi_hold", use_alt_ctr, 15);

      // Non-training updates that would otherwise decrement
      set_upd(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      check("noupd.same_pred", use_alt_ctr, 15);
      set_upd(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check("noupd.not_weak", use_alt_ctr, 15);
      set_upd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check("noupd.no_valid", use_alt_ctr, 15);

      // Saturate downward: 20 provider-correct updates
      set_upd(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check("sat.dec1", use_alt_ctr, 14);
      for (int i = 0; i < 19; i++) tick();
      check("sat.lo", use_alt_ctr, 0);
      tick();
      check("sat.lo_hold", use_alt_ctr, 0);
      set_upd(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check("noupd.lo_not_weak", use_alt_ctr, 0);

      // Reset mid-stream overrides a concurrent lookup and increment
      set_upd(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      check("mid.pre_ctr", use_alt_ctr, 1);
      lookup_valid = 1'b1; tag_eq = 4'b0101;
      C_bits = {3'd0, 3'd6, 3'd0, 3'd1};
      tick();
      check("mid.pre_provider_idx", provider_idx, 3);
      reset = 1'b0;
      tick();
      check("mid.pred_valid", pred_valid, 0);
      check("mid.provider_idx", provider_idx, 0);
      check("mid.alt_idx", alt_idx, 0);
      check("mid.branch_prediction", branch_prediction, 1'b0);
      check("mid.use_alt_ctr", use_alt_ctr, 7);

      reset = 1'b1;
      set_upd(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("post.provider_idx", provider_idx, 3);
      check("post.pred_valid", pred_valid, 1);
      check("post.use_alt_ctr", use_alt_ctr, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
